// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared constants and parameter-legality helper for the toggle-event
// receive path. Imported by multi_toggle_event_rx and toggle_event_ch.
//   SYNC_STAGES_MIN     : fewest synchroniser flops allowed on a channel
//   SYNC_STAGES_DEFAULT : synchroniser depth used when none is given
//   params_legal()      : elaboration-time check of the block parameters
// ----------------------------------------------------------------------------
package cdc_pkg;

   localparam int SYNC_STAGES_MIN     = 2;
   localparam int SYNC_STAGES_DEFAULT = 2;

   function automatic bit params_legal(input int num_ch,
                                       input int sync_stages,
                                       input int cnt_w);
      return (num_ch >= 1) && (sync_stages >= SYNC_STAGES_MIN) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/toggle_event_ch.sv
// ----------------------------------------------------------------------------
// toggle_event_ch
// One receive channel: synchronises an asynchronous toggle line, turns each
// level change into a one-cycle event pulse, and keeps the pending/ack
// handshake plus the sticky overflow flag and saturating drop counter.
// Ports:
//   clk, aresetn   : clock, synchronous active-low reset
//   src_toggle     : asynchronous toggle line (one event per level change)
//   armed          : from the top; edges are ignored until set
//   evt_ack        : consumer acknowledge for the pending event
//   clr_overflow   : clears overflow flag and drop counter
//   evt_pulse      : registered one-cycle event pulse
//   evt_pending    : event waiting for acknowledge
//   evt_overflow   : sticky, an event was dropped while pending
//   drop_cnt       : saturating count of dropped events
// ----------------------------------------------------------------------------
module toggle_event_ch
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             src_toggle,
   input  logic             armed,
   input  logic             evt_ack,
   input  logic             clr_overflow,
   output logic             evt_pulse,
   output logic             evt_pending,
   output logic             evt_overflow,
   output logic [CNT_W-1:0] drop_cnt
);

   logic [SYNC_STAGES-1:0] tog_sync;
   logic                   tog_prev;
   logic                   edge_det;
   logic                   evt;
   logic                   drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Detection stage: last sync flop against its previous value.
   // The edge is only acted on once the channel has been armed, so a line
   // resting high out of reset cannot masquerade as an event.
   assign edge_det = tog_sync[SYNC_STAGES-1] ^ tog_prev;
   assign evt      = armed & edge_det;
   assign drop     = evt & evt_pending & ~evt_ack;

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         tog_sync     <= '0;
         tog_prev     <= 1'b0;
         evt_pulse    <= 1'b0;
         evt_pending  <= 1'b0;
         evt_overflow <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         // Synchroniser stage: shift the raw toggle line through the chain
         tog_sync <= {tog_sync[SYNC_STAGES-2:0], src_toggle};
         tog_prev <= tog_sync[SYNC_STAGES-1];

         // Event/handshake stage
         evt_pulse <= evt;

         // A new event keeps pending set whether or not the old one is
         // acked in the same cycle; only an ack without a new event clears.
         if (evt)
            evt_pending <= 1'b1;
         else if (evt_ack)
            evt_pending <= 1'b0;

         // A drop coinciding with a clear wins: the clear empties the
         // counter and the drop is then counted as the first one.
         if (drop) begin
            evt_overflow <= 1'b1;
            drop_cnt     <= clr_overflow ? CNT_W'(1) : sat_inc(drop_cnt);
         end else if (clr_overflow) begin
            evt_overflow <= 1'b0;
            drop_cnt     <= '0;
         end
      end
   end

endmodule

// File: rtl/multi_toggle_event_rx.sv
// ----------------------------------------------------------------------------
// multi_toggle_event_rx
// Receive-side collector for toggle-encoded events from foreign clock domains.
// NUM_CH independent channels, each synchronised and turned into a pulse with
// a pending/ack handshake and drop tracking. A shared arm counter suppresses
// events until the synchronisers have captured a post-reset baseline.
// Ports:
//   clk, aresetn   : clock, synchronous active-low reset
//   src_toggle     : NUM_CH asynchronous toggle lines
//   evt_pulse      : NUM_CH one-cycle event pulses
//   evt_pending    : NUM_CH events awaiting acknowledge
//   evt_ack        : NUM_CH consumer acknowledges
//   evt_overflow   : NUM_CH sticky drop flags
//   drop_cnt       : packed drop counters, channel i at [i*CNT_W +: CNT_W]
//   clr_overflow   : clears all overflow flags and drop counters
//   armed          : high once baseline capture after reset is complete
// ----------------------------------------------------------------------------
module multi_toggle_event_rx
   import cdc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int CNT_W       = 4
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [NUM_CH-1:0]       src_toggle,
   output logic [NUM_CH-1:0]       evt_pulse,
   output logic [NUM_CH-1:0]       evt_pending,
   input  logic [NUM_CH-1:0]       evt_ack,
   output logic [NUM_CH-1:0]       evt_overflow,
   output logic [NUM_CH*CNT_W-1:0] drop_cnt,
   input  logic                    clr_overflow,
   output logic                    armed
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);

   if (!params_legal(NUM_CH, SYNC_STAGES, CNT_W)) begin : g_param_check
      $error("multi_toggle_event_rx: illegal parameters (NUM_CH>=1, SYNC_STAGES>=%0d, CNT_W>=1)",
             SYNC_STAGES_MIN);
   end

   logic [ARM_W-1:0] arm_cnt;

   // Arming: SYNC_STAGES+1 edges after release the chains and edge history
   // all hold the current line levels, so any difference seen afterwards is
   // a genuine event.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else if (!armed) begin
         if (arm_cnt == ARM_W'(SYNC_STAGES))
            armed <= 1'b1;
         else
            arm_cnt <= arm_cnt + ARM_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      toggle_event_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk          (clk),
         .aresetn      (aresetn),
         .src_toggle   (src_toggle[i]),
         .armed        (armed),
         .evt_ack      (evt_ack[i]),
         .clr_overflow (clr_overflow),
         .evt_pulse    (evt_pulse[i]),
         .evt_pending  (evt_pending[i]),
         .evt_overflow (evt_overflow[i]),
         .drop_cnt     (drop_cnt[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_multi_toggle_event_rx.sv
// ----------------------------------------------------------------------------
// tb_multi_toggle_event_rx
// Directed scenarios plus randomized traffic for multi_toggle_event_rx,
// checked against a behavioural model of the event rules.
// ----------------------------------------------------------------------------
module tb_multi_toggle_event_rx;

   localparam int NUM_CH = 4;
   localparam int S      = 2;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int VW     = 1 + 3*NUM_CH + NUM_CH*CNT_W;

   logic                    clk = 1'b0;
   logic                    aresetn = 1'b0;
   logic [NUM_CH-1:0]       src_toggle = '0;
   logic [NUM_CH-1:0]       evt_ack = '0;
   logic                    clr_overflow = 1'b0;
   logic [NUM_CH-1:0]       evt_pulse;
   logic [NUM_CH-1:0]       evt_pending;
   logic [NUM_CH-1:0]       evt_overflow;
   logic [NUM_CH*CNT_W-1:0] drop_cnt;
   logic                    armed;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   logic [NUM_CH-1:0] m_lvl [S+1];   // line level sampled at recent edges, [0] newest
   int                m_since = 0;   // edges since reset release
   logic [NUM_CH-1:0] m_pulse = '0;
   logic [NUM_CH-1:0] m_pend  = '0;
   logic [NUM_CH-1:0] m_ovf   = '0;
   int                m_cnt [NUM_CH];

   always #5 clk = ~clk;

   multi_toggle_event_rx #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (S),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .src_toggle   (src_toggle),
      .evt_pulse    (evt_pulse),
      .evt_pending  (evt_pending),
      .evt_ack      (evt_ack),
      .evt_overflow (evt_overflow),
      .drop_cnt     (drop_cnt),
      .clr_overflow (clr_overflow),
      .armed        (armed)
   );

   // Model update for one rising edge, using the inputs present at that edge.
   // A line change sampled at edge n is seen as an event at edge n+S, and
   // only counts if S+1 edges have passed since reset release before it.
   task automatic model_edge();
      logic [NUM_CH-1:0] chg;
      bit                live;
      bit                e;
      if (!aresetn) begin
         for (int k = 0; k <= S; k++) m_lvl[k] = '0;
         m_since = 0;
         m_pulse = '0;
         m_pend  = '0;
         m_ovf   = '0;
         for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
         return;
      end
      chg  = m_lvl[S-1] ^ m_lvl[S];
      live = (m_since >= S + 1);
      for (int k = S; k > 0; k--) m_lvl[k] = m_lvl[k-1];
      m_lvl[0] = src_toggle;
      m_since++;
      for (int c = 0; c < NUM_CH; c++) begin
         e = live && chg[c];
         m_pulse[c] = e;
         if (e && m_pend[c] && !evt_ack[c]) begin
            m_ovf[c] = 1'b1;
            m_cnt[c] = clr_overflow ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
         end else if (clr_overflow) begin
            m_ovf[c] = 1'b0;
            m_cnt[c] = 0;
         end
         if (e) m_pend[c] = 1'b1;
         else if (evt_ack[c]) m_pend[c] = 1'b0;
      end
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [NUM_CH*CNT_W-1:0] d;
      for (int c = 0; c < NUM_CH; c++) d[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      return {(m_since >= S + 1), m_pulse, m_pend, m_ovf, d};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {armed, evt_pulse, evt_pending, evt_overflow, drop_cnt};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic toggle(input int ch);
      src_toggle[ch] = ~src_toggle[ch];
   endtask

   task automatic test_reset();
      aresetn    = 1'b0;
      src_toggle = 4'b1010;
      step();
      step();
      total++;
      if (dut_vec() !== '0) begin
         bad++;
         $display("FAIL reset_state: got=%h want=0", dut_vec());
      end
      aresetn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         total++;
         if (armed !== 1'(k >= 3)) begin
            bad++;
            $display("FAIL reset_arm cycle %0d: got=%b want=%b", k, armed, (k >= 3));
         end
         total++;
         if ({evt_pulse, evt_pending, evt_overflow, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_quiet cycle %0d: pulse=%b pend=%b ovf=%b drop=%h want all 0",
                     k, evt_pulse, evt_pending, evt_overflow, drop_cnt);
         end
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL reset_model cycle %0d: got=%h want=%h", k, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_single();
      toggle(0);
      for (int k = 1; k <= 5; k++) begin
         step();
         total++;
         if (evt_pulse[0] !== 1'(k == 3)) begin
            bad++;
            $display("FAIL single_pulse cycle %0d: got=%b want=%b", k, evt_pulse[0], (k == 3));
         end
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL single_model cycle %0d: got=%h want=%h", k, dut_vec(), model_vec());
         end
      end
      total++;
      if (evt_pending[0] !== 1'b1) begin
         bad++;
         $display("FAIL single_pending: got=%b want=1", evt_pending[0]);
      end
      evt_ack[0] = 1'b1;
      step();
      evt_ack[0] = 1'b0;
      total++;
      if ({evt_pending[0], evt_overflow[0]} !== 2'b00) begin
         bad++;
         $display("FAIL single_ack: pend=%b ovf=%b want 0 0", evt_pending[0], evt_overflow[0]);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++;
         $display("FAIL single_ack_model: got=%h want=%h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_overflow();
      for (int e = 0; e < 3; e++) begin
         toggle(1);
         for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
               bad++;
               $display("FAIL ovf_model ev%0d: got=%h want=%h", e, dut_vec(), model_vec());
            end
         end
      end
      total++;
      if ({evt_pending[1], evt_overflow[1], drop_cnt[1*CNT_W +: CNT_W]} !== {1'b1, 1'b1, CNT_W'(2)}) begin
         bad++;
         $display("FAIL ovf_ch1: pend=%b ovf=%b drop=%0d want 1 1 2",
                  evt_pending[1], evt_overflow[1], drop_cnt[1*CNT_W +: CNT_W]);
      end
   endtask

   task automatic test_ack_collision();
      toggle(2);
      for (int k = 0; k < 4; k++) step();
      total++;
      if (evt_pending[2] !== 1'b1) begin
         bad++;
         $display("FAIL coll_first_pending: got=%b want=1", evt_pending[2]);
      end
      toggle(2);
      step();
      step();
      evt_ack[2] = 1'b1;
      step();
      evt_ack[2] = 1'b0;
      total++;
      if ({evt_pulse[2], evt_pending[2], evt_overflow[2], drop_cnt[2*CNT_W +: CNT_W]} !==
          {1'b1, 1'b1, 1'b0, CNT_W'(0)}) begin
         bad++;
         $display("FAIL coll_ch2: pulse=%b pend=%b ovf=%b drop=%0d want 1 1 0 0", evt_pulse[2],
                  evt_pending[2], evt_overflow[2], drop_cnt[2*CNT_W +: CNT_W]);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++;
         $display("FAIL coll_model: got=%h want=%h", dut_vec(), model_vec());
      end
      step();
      evt_ack[2] = 1'b1;
      step();
      evt_ack[2] = 1'b0;
      total++;
      if (evt_pending[2] !== 1'b0) begin
         bad++;
         $display("FAIL coll_release: got=%b want=0", evt_pending[2]);
      end
   endtask

   task automatic test_clr_drop();
      toggle(3);
      for (int k = 0; k < 4; k++) step();
      toggle(3);
      step();
      step();
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      total++;
      if ({evt_overflow[3], drop_cnt[3*CNT_W +: CNT_W]} !== {1'b1, CNT_W'(1)}) begin
         bad++;
         $display("FAIL clr_ch3: ovf=%b drop=%0d want 1 1", evt_overflow[3], drop_cnt[3*CNT_W +: CNT_W]);
      end
      total++;
      if ({evt_overflow[1], drop_cnt[1*CNT_W +: CNT_W]} !== {1'b0, CNT_W'(0)}) begin
         bad++;
         $display("FAIL clr_ch1: ovf=%b drop=%0d want 0 0", evt_overflow[1], drop_cnt[1*CNT_W +: CNT_W]);
      end
      total++;
      if (evt_pending !== 4'b1010) begin
         bad++;
         $display("FAIL clr_pending: got=%b want=1010", evt_pending);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++;
         $display("FAIL clr_model: got=%h want=%h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_saturate();
      for (int e = 0; e < 5; e++) begin
         toggle(1);
         for (int k = 0; k < 4; k++) step();
         total++;
         if (drop_cnt[1*CNT_W +: CNT_W] !== CNT_W'((e + 1 < CMAX) ? e + 1 : CMAX)) begin
            bad++;
            $display("FAIL sat_ch1 ev%0d: got=%0d want=%0d", e, drop_cnt[1*CNT_W +: CNT_W],
                     (e + 1 < CMAX) ? e + 1 : CMAX);
         end
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL sat_model ev%0d: got=%h want=%h", e, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      toggle(0);
      step();
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      total++;
      if (dut_vec() !== '0) begin
         bad++;
         $display("FAIL midrst_state: got=%h want=0", dut_vec());
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         total++;
         if (evt_pulse !== '0) begin
            bad++;
            $display("FAIL midrst_pulse cycle %0d: got=%b want=0000", k, evt_pulse);
         end
         total++;
         if (armed !== 1'(k >= 3)) begin
            bad++;
            $display("FAIL midrst_arm cycle %0d: got=%b want=%b", k, armed, (k >= 3));
         end
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL midrst_model cycle %0d: got=%h want=%h", k, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_random();
      int last [NUM_CH];
      for (int c = 0; c < NUM_CH; c++) last[c] = -10;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ((cyc - last[c] >= 3) && ($urandom_range(0, 2) == 0)) begin
               toggle(c);
               last[c] = cyc;
            end
         end
         evt_ack      = NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
         clr_overflow = ($urandom_range(0, 15) == 0);
         step();
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL random_model cycle %0d: got=%h want=%h", cyc, dut_vec(), model_vec());
         end
      end
      evt_ack      = '0;
      clr_overflow = 1'b0;
   endtask

   initial begin
      for (int k = 0; k <= S; k++) m_lvl[k] = '0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
      test_reset();
      test_single();
      test_overflow();
      test_ack_collision();
      test_clr_drop();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_toggle_event_rx.md
Name: multi_toggle_event_rx

Overview:
Receive-side event collector for toggle-encoded events arriving from foreign clock domains. It generalises per-signal pulse transfer into NUM_CH channels, with configurable synchroniser depth and a per-channel pending/ack handshake. It also tracks events lost while a channel is still pending, using a sticky overflow flag and a saturating drop counter. The block sits in the APB-side domain of the AXI-Lite-to-APB converter and collects start/done events for the transaction controller.

Parameters:
NUM_CH, 4, number of independent event channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2; elaboration error below 2)
CNT_W, 4, width of per-channel drop counter (>=1)

Ports:
clk  input  1  single clock; all logic on rising edge
aresetn  input  1  synchronous, active-low reset
src_toggle  input  NUM_CH  asynchronous toggle lines; each change of level = one event
evt_pulse  output  NUM_CH  one-cycle pulse per detected event
evt_pending  output  NUM_CH  event waiting for consumer ack
evt_ack  input  NUM_CH  consumer acknowledge, sampled per channel
evt_overflow  output  NUM_CH  sticky: event arrived while pending and not acked
drop_cnt  output  NUM_CH*CNT_W  packed per-channel count of dropped events; channel i at [i*CNT_W +: CNT_W]
clr_overflow  input  1  clears evt_overflow and drop_cnt on all channels
armed  output  1  high once post-reset baseline capture has completed

Behaviour:
- Reset (aresetn low at a rising edge): sync chains, edge-history register, evt_pulse, evt_pending, evt_overflow, drop_cnt, armed all 0. Arm counter is 0.
- Sync chain per channel: s[0] <= src_toggle[i]; s[k] <= s[k-1]. edge_det = s[SYNC_STAGES-1] ^ prev; prev <= s[SYNC_STAGES-1] every cycle.
- Arming:
  - After reset deassertion, an arm counter runs SYNC_STAGES+1 cycles. armed goes high on the edge that completes the count.
  - While armed=0, edge_det is ignored: no pulse, no pending, no drop. prev still tracks.
  - Consequence: a toggle line sitting at 1 out of reset never produces a spurious event.
- Latency: a src_toggle change meeting setup before edge n gives evt_pulse high for exactly the cycle after edge n+SYNC_STAGES (2 cycles for default). Registered, glitch-free.
- A second change of the same channel must be at least 2 clk cycles after the first. Faster toggling is outside the contract; the bench does not check it.
- evt_pending per channel, evaluated at each edge with E = armed & edge_det:
  - E=1, pending=0: pending<=1.
  - E=1, pending=1, ack=1: pending stays 1 (old event consumed, new one latched). No overflow.
  - E=1, pending=1, ack=0: pending stays 1, overflow<=1, drop_cnt<=drop_cnt+1 saturating at 2^CNT_W-1.
  - E=0, ack=1, pending=1: pending<=0.
  - ack while pending=0: ignored.
- evt_pending rises in the same cycle as evt_pulse. ack is honoured from that cycle on.
- clr_overflow:
  - Clears evt_overflow and drop_cnt on all channels at the next edge.
  - If a drop happens on a channel in the same cycle, the drop wins for that channel: overflow=1, drop_cnt=1.
  - Does not affect pending.
- Channels are fully independent; simultaneous events on all channels are each handled.
- Reset mid-operation: all state cleared at that edge; events in flight in the sync chain are discarded; arming restarts.

Decomposition:
- Shared package cdc_pkg holds:
  - SYNC_STAGES_MIN = 2;
  - default SYNC_STAGES;
  - an elaboration-time check function for parameter legality.
- One natural sub-module: toggle_event_ch. It holds a single channel's sync chain, edge detect, pending, overflow and drop counter. The top instantiates it NUM_CH times in a generate loop and owns the shared arm counter and clr_overflow fan-out.

Test Plan:
1. Reset release with src_toggle=4'b1010 held -> armed high at cycle 3 after release (SYNC_STAGES=2); no evt_pulse, evt_pending=0, drop_cnt=0.
2. After arming, toggle ch0 once -> evt_pulse[0] high exactly 1 cycle, 2 cycles after the sampling edge; evt_pending[0]=1; ack 1 cycle later -> evt_pending[0]=0, overflow=0.
3. ch1: three events spaced 4 cycles apart, no ack -> evt_pending[1]=1, evt_overflow[1]=1, drop_cnt ch1=2; then with CNT_W=2, 5 unacked events -> drop_cnt saturates at 3.
4. ch2 new event arriving in the same cycle as evt_ack[2] on an older pending event -> evt_pending[2] stays 1, evt_overflow[2]=0, drop_cnt=0.
5. clr_overflow in the same cycle as a drop on ch3, while ch1 has drop_cnt=2 -> ch3 overflow=1, drop_cnt=1; ch1 overflow=0, drop_cnt=0; pending values unchanged.
6. aresetn low for 1 cycle while ch0 event is mid-sync-chain -> all outputs 0, no evt_pulse after release, armed re-asserts after 3 cycles.
